// File: rtl/odesa_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | odesa_pkg : shared types, widths and saturating add for the layer    |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
package odesa_pkg;

    localparam int C_DEF_IW   = 9;
    localparam int C_DEF_WW   = 9;
    localparam int C_DEF_V    = C_DEF_IW + C_DEF_WW + 1;
    localparam int C_ARITH_W  = 40;
    localparam int C_SHIFT_W  = 5;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SCAN   = 3'd1,
        S_FIRE   = 3'd2,
        S_UPD_W1 = 3'd3,
        S_UPD_W2 = 3'd4,
        S_UPD_TH = 3'd5,
        S_DECAY  = 3'd6
    } state_t;

    function automatic int v_width(input int iw, input int ww);
        v_width = iw + ww + 1;
    endfunction

    // Clamp a + b into [0, max_v]; operands are wide enough never to wrap.
    function automatic logic signed [C_ARITH_W-1:0] sat_add(
        input logic signed [C_ARITH_W-1:0] a,
        input logic signed [C_ARITH_W-1:0] b,
        input logic signed [C_ARITH_W-1:0] max_v
    );
        logic signed [C_ARITH_W-1:0] s;
        s = a + b;
        if (s < 0)
            sat_add = '0;
        else if (s > max_v)
            sat_add = max_v;
        else
            sat_add = s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/odesa_lr_update.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | odesa_lr_update : next = sat(cur + ((target - cur) >>> shift))       |
// | Revision        : 1.0                                                |
// +----------------------------------------------------------------------+
module odesa_lr_update
    import odesa_pkg::*;
#(
    parameter int P_WIDTH = C_DEF_V
) (
    input  logic [P_WIDTH-1:0]   i_cur,
    input  logic [P_WIDTH-1:0]   i_target,
    input  logic [P_WIDTH-1:0]   i_max,
    input  logic [C_SHIFT_W-1:0] i_shift,
    output logic [P_WIDTH-1:0]   o_next
);

    logic signed [C_ARITH_W-1:0] w_cur;
    logic signed [C_ARITH_W-1:0] w_tgt;
    logic signed [C_ARITH_W-1:0] w_max;
    logic signed [C_ARITH_W-1:0] w_step;
    logic signed [C_ARITH_W-1:0] w_sum;
    logic                        w_unused_hi;

    assign w_cur  = $signed({{(C_ARITH_W-P_WIDTH){1'b0}}, i_cur});
    assign w_tgt  = $signed({{(C_ARITH_W-P_WIDTH){1'b0}}, i_target});
    assign w_max  = $signed({{(C_ARITH_W-P_WIDTH){1'b0}}, i_max});
    assign w_step = (w_tgt - w_cur) >>> i_shift;
    assign w_sum  = sat_add(w_cur, w_step, w_max);

    assign o_next      = w_sum[P_WIDTH-1:0];
    assign w_unused_hi = ^w_sum[C_ARITH_W-1:P_WIDTH];

endmodule
`default_nettype wire

// File: rtl/odesa_layer_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | odesa_layer_ctrl : winner-take-all sequencer and parameter store     |
// | Revision         : 1.0                                               |
// +----------------------------------------------------------------------+
module odesa_layer_ctrl
    import odesa_pkg::*;
#(
    parameter int P_NEURONS      = 4,
    parameter int P_INPUT_WIDTH  = C_DEF_IW,
    parameter int P_WEIGHT_WIDTH = C_DEF_WW,
    parameter int P_ETA_SHIFT    = 4,
    parameter int P_TH_DEC       = 1,
    parameter int P_W_INIT       = 64,
    parameter int P_TH_INIT      = 256
) (
    input  logic                                                  i_clk,
    input  logic                                                  i_rst,
    input  logic                                                  i_event_valid,
    input  logic                                                  i_learn_en,
    input  logic [P_NEURONS*(P_INPUT_WIDTH+P_WEIGHT_WIDTH+1)-1:0] i_neuron_out,
    input  logic [P_INPUT_WIDTH-1:0]                              i_tr_1,
    input  logic [P_INPUT_WIDTH-1:0]                              i_tr_2,
    output logic [P_NEURONS*P_WEIGHT_WIDTH-1:0]                   o_weight_1,
    output logic [P_NEURONS*P_WEIGHT_WIDTH-1:0]                   o_weight_2,
    output logic [P_NEURONS*(P_INPUT_WIDTH+P_WEIGHT_WIDTH+1)-1:0] o_threshold,
    output logic [P_NEURONS-1:0]                                  o_spike,
    output logic [$clog2(P_NEURONS)-1:0]                          o_winner,
    output logic                                                  o_winner_vld,
    output logic                                                  o_busy,
    output logic                                                  o_drop
);

    localparam int C_V  = v_width(P_INPUT_WIDTH, P_WEIGHT_WIDTH);
    localparam int C_IW = P_INPUT_WIDTH;
    localparam int C_WW = P_WEIGHT_WIDTH;
    localparam int C_CW = $clog2(P_NEURONS);

    localparam logic [C_V-1:0]  C_TH_DEC  = C_V'(P_TH_DEC);
    localparam logic [C_V-1:0]  C_TH_INIT = C_V'(P_TH_INIT);
    localparam logic [C_V-1:0]  C_TH_MAX  = {C_V{1'b1}};
    localparam logic [C_V-1:0]  C_W_MAX   = C_V'({C_WW{1'b1}});
    localparam logic [C_WW-1:0] C_W_INIT  = C_WW'(P_W_INIT);
    localparam logic [C_CW-1:0] C_LAST    = C_CW'(P_NEURONS - 1);

    state_t                         r_state;
    state_t                         w_next_state;
    logic [P_NEURONS-1:0][C_V-1:0]  r_outs;
    logic [C_IW-1:0]                r_tr1;
    logic [C_IW-1:0]                r_tr2;
    logic                           r_learn;
    logic [C_CW-1:0]                r_cnt;
    logic [C_CW-1:0]                r_best_idx;
    logic [C_CW-1:0]                r_winner;
    logic [C_V-1:0]                 r_best;
    logic [C_WW-1:0]                r_w1 [P_NEURONS];
    logic [C_WW-1:0]                r_w2 [P_NEURONS];
    logic [C_V-1:0]                 r_th [P_NEURONS];

    logic [C_V-1:0]                 w_cand;
    logic                           w_take;
    logic                           w_last;
    logic                           w_found;
    logic [C_V-1:0]                 w_lr_cur;
    logic [C_V-1:0]                 w_lr_tgt;
    logic [C_V-1:0]                 w_lr_max;
    logic [C_V-1:0]                 w_lr_next;
    logic [P_NEURONS-1:0]           w_onehot;

    // Strict compare keeps the lowest index on ties; best=0 rejects silent neurons.
    assign w_cand  = r_outs[r_cnt];
    assign w_take  = w_cand > r_best;
    assign w_last  = (r_cnt == C_LAST);
    assign w_found = w_take || (r_best != '0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_outs     <= '0;
            r_tr1      <= '0;
            r_tr2      <= '0;
            r_learn    <= 1'b0;
            r_cnt      <= '0;
            r_best     <= '0;
            r_best_idx <= '0;
            r_winner   <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (i_event_valid) begin
                        r_outs     <= i_neuron_out;
                        r_tr1      <= i_tr_1;
                        r_tr2      <= i_tr_2;
                        r_learn    <= i_learn_en;
                        r_cnt      <= '0;
                        r_best     <= '0;
                        r_best_idx <= '0;
                    end
                end
                S_SCAN: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_take) begin
                        r_best     <= w_cand;
                        r_best_idx <= r_cnt;
                    end
                    if (w_last && w_found)
                        r_winner <= w_take ? r_cnt : r_best_idx;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (i_event_valid) w_next_state = S_SCAN;
            S_SCAN:   if (w_last) w_next_state = w_found ? S_FIRE : S_DECAY;
            S_FIRE:   w_next_state = r_learn ? S_UPD_W1 : S_IDLE;
            S_UPD_W1: w_next_state = S_UPD_W2;
            S_UPD_W2: w_next_state = S_UPD_TH;
            S_UPD_TH: w_next_state = S_IDLE;
            S_DECAY:  w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // One learning-rule unit, operands steered by the update phase.
    always_comb begin
        w_lr_cur = '0;
        w_lr_tgt = '0;
        w_lr_max = '0;
        case (r_state)
            S_UPD_W1: begin
                w_lr_cur = C_V'(r_w1[r_winner]);
                w_lr_tgt = C_V'(r_tr1);
                w_lr_max = C_W_MAX;
            end
            S_UPD_W2: begin
                w_lr_cur = C_V'(r_w2[r_winner]);
                w_lr_tgt = C_V'(r_tr2);
                w_lr_max = C_W_MAX;
            end
            S_UPD_TH: begin
                w_lr_cur = r_th[r_winner];
                w_lr_tgt = r_best;
                w_lr_max = C_TH_MAX;
            end
            default: ;
        endcase
    end

    odesa_lr_update #(
        .P_WIDTH (C_V)
    ) u_lr_update (
        .i_cur    (w_lr_cur),
        .i_target (w_lr_tgt),
        .i_max    (w_lr_max),
        .i_shift  (C_SHIFT_W'(P_ETA_SHIFT)),
        .o_next   (w_lr_next)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < P_NEURONS; k++) begin
                r_w1[k] <= C_W_INIT;
                r_w2[k] <= C_W_INIT;
                r_th[k] <= C_TH_INIT;
            end
        end else begin
            case (r_state)
                S_UPD_W1: r_w1[r_winner] <= w_lr_next[C_WW-1:0];
                S_UPD_W2: r_w2[r_winner] <= w_lr_next[C_WW-1:0];
                S_UPD_TH: r_th[r_winner] <= w_lr_next;
                S_DECAY: begin
                    for (int k = 0; k < P_NEURONS; k++)
                        r_th[k] <= (r_th[k] > C_TH_DEC) ? r_th[k] - C_TH_DEC : '0;
                end
                default: ;
            endcase
        end
    end

    generate
        for (genvar k = 0; k < P_NEURONS; k++) begin : g_pack
            assign o_weight_1[k*C_WW +: C_WW] = r_w1[k];
            assign o_weight_2[k*C_WW +: C_WW] = r_w2[k];
            assign o_threshold[k*C_V +: C_V]  = r_th[k];
        end
    endgenerate

    assign w_onehot     = {{(P_NEURONS-1){1'b0}}, 1'b1} << r_winner;
    assign o_spike      = (r_state == S_FIRE) ? w_onehot : '0;
    assign o_winner     = r_winner;
    assign o_winner_vld = (r_state == S_FIRE);
    assign o_busy       = (r_state != S_IDLE);
    assign o_drop       = i_event_valid && (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_odesa_layer_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_odesa_layer_ctrl : scoreboard bench with a reference layer model  |
// | Revision            : 1.0                                            |
// +----------------------------------------------------------------------+
module tb_odesa_layer_ctrl;

    localparam int N       = 4;
    localparam int IW      = 9;
    localparam int WW      = 9;
    localparam int V       = IW + WW + 1;
    localparam int ETA     = 4;
    localparam int W_INIT  = 64;
    localparam int TH_INIT = 256;
    localparam int TH_DEC  = 1;
    localparam int W_MAX   = (1 << WW) - 1;
    localparam int TH_MAX  = (1 << V) - 1;

    logic                 i_clk = 1'b0;
    logic                 i_rst;
    logic                 i_event_valid;
    logic                 i_learn_en;
    logic [N*V-1:0]       i_neuron_out;
    logic [IW-1:0]        i_tr_1;
    logic [IW-1:0]        i_tr_2;
    logic [N*WW-1:0]      o_weight_1;
    logic [N*WW-1:0]      o_weight_2;
    logic [N*V-1:0]       o_threshold;
    logic [N-1:0]         o_spike;
    logic [$clog2(N)-1:0] o_winner;
    logic                 o_winner_vld;
    logic                 o_busy;
    logic                 o_drop;

    odesa_layer_ctrl #(
        .P_NEURONS      (N),
        .P_INPUT_WIDTH  (IW),
        .P_WEIGHT_WIDTH (WW),
        .P_ETA_SHIFT    (ETA),
        .P_TH_DEC       (TH_DEC),
        .P_W_INIT       (W_INIT),
        .P_TH_INIT      (TH_INIT)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_event_valid (i_event_valid),
        .i_learn_en    (i_learn_en),
        .i_neuron_out  (i_neuron_out),
        .i_tr_1        (i_tr_1),
        .i_tr_2        (i_tr_2),
        .o_weight_1    (o_weight_1),
        .o_weight_2    (o_weight_2),
        .o_threshold   (o_threshold),
        .o_spike       (o_spike),
        .o_winner      (o_winner),
        .o_winner_vld  (o_winner_vld),
        .o_busy        (o_busy),
        .o_drop        (o_drop)
    );

    always #5 i_clk = ~i_clk;

    int unsigned cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        int          idx;
        int unsigned cyc;
    } spike_t;

    typedef struct {
        int w1 [N];
        int w2 [N];
        int th [N];
    } params_t;

    spike_t  sq [$];
    params_t pq [$];
    params_t m;
    int      errors = 0;
    int      checks = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Learning rule from first principles: step = floor((tgt - cur) / 2^ETA).
    function automatic int lr(input int cur, input int tgt, input int mx);
        int d, step, r, div;
        div = 1 << ETA;
        d = tgt - cur;
        step = (d >= 0) ? d / div : -((-d + div - 1) / div);
        r = cur + step;
        if (r < 0) r = 0;
        if (r > mx) r = mx;
        return r;
    endfunction

    function automatic logic [N*V-1:0] pack(input int a, input int b, input int c, input int d);
        logic [N*V-1:0] r;
        r[0*V +: V] = V'(a);
        r[1*V +: V] = V'(b);
        r[2*V +: V] = V'(c);
        r[3*V +: V] = V'(d);
        return r;
    endfunction

    task automatic model_init();
        for (int k = 0; k < N; k++) begin
            m.w1[k] = W_INIT;
            m.w2[k] = W_INIT;
            m.th[k] = TH_INIT;
        end
    endtask

    task automatic check_params(input string tag, input params_t e);
        for (int k = 0; k < N; k++) begin
            chk($sformatf("%s_w1[%0d]", tag, k), longint'(o_weight_1[k*WW +: WW]), e.w1[k]);
            chk($sformatf("%s_w2[%0d]", tag, k), longint'(o_weight_2[k*WW +: WW]), e.w2[k]);
            chk($sformatf("%s_th[%0d]", tag, k), longint'(o_threshold[k*V +: V]), e.th[k]);
        end
    endtask

    task automatic do_reset();
        i_rst         = 1'b1;
        i_event_valid = 1'b0;
        model_init();
        pq.delete();
        sq.delete();
        @(negedge i_clk);
        @(negedge i_clk);
        #2 i_rst = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge i_clk);
        while (o_busy && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        if (o_busy) chk("idle_timeout", 1, 0);
    endtask

    // Drives one event when idle and records what the layer must do with it.
    task automatic send(input logic [N*V-1:0] outs, input int t1, input int t2, input bit learn);
        int          best, idx, o;
        int unsigned ev_cyc;
        spike_t      s;
        wait_idle();
        i_event_valid = 1'b1;
        i_neuron_out  = outs;
        i_tr_1        = IW'(t1);
        i_tr_2        = IW'(t2);
        i_learn_en    = learn;
        #1 chk("drop_idle", o_drop, 0);
        @(posedge i_clk);
        #1;
        i_event_valid = 1'b0;
        ev_cyc = cyc;
        best = 0;
        idx  = -1;
        for (int k = 0; k < N; k++) begin
            o = int'(outs[k*V +: V]);
            if (o > best) begin
                best = o;
                idx  = k;
            end
        end
        if (idx >= 0) begin
            s.idx = idx;
            s.cyc = ev_cyc + N;
            sq.push_back(s);
            if (learn) begin
                m.w1[idx] = lr(m.w1[idx], t1, W_MAX);
                m.w2[idx] = lr(m.w2[idx], t2, W_MAX);
                m.th[idx] = lr(m.th[idx], best, TH_MAX);
            end
        end else begin
            for (int k = 0; k < N; k++)
                m.th[k] = (m.th[k] > TH_DEC) ? m.th[k] - TH_DEC : 0;
        end
        pq.push_back(m);
    endtask

    // Monitor: spikes against the spike queue, parameters at end of each sequence.
    initial begin
        bit      prev_busy;
        spike_t  e;
        params_t p;
        prev_busy = 1'b0;
        forever begin
            @(negedge i_clk);
            if (!i_rst) begin
                if (o_winner_vld) begin
                    if (sq.size() == 0) begin
                        chk("spike_unexpected", 1, 0);
                    end else begin
                        e = sq.pop_front();
                        chk("spike_onehot", o_spike, 1 << e.idx);
                        chk("winner_idx", o_winner, e.idx);
                        chk("spike_cycle", cyc, e.cyc);
                    end
                end else begin
                    chk("spike_quiet", o_spike, 0);
                end
                if (prev_busy && !o_busy) begin
                    if (pq.size() == 0) begin
                        chk("params_unexpected", 1, 0);
                    end else begin
                        p = pq.pop_front();
                        check_params("seq", p);
                    end
                end
            end
            prev_busy = o_busy;
        end
    end

    initial begin
        logic [N*V-1:0] outs;
        int             v, prev;
        i_rst         = 1'b1;
        i_event_valid = 1'b0;
        i_learn_en    = 1'b0;
        i_neuron_out  = '0;
        i_tr_1        = '0;
        i_tr_2        = '0;
        do_reset();

        @(negedge i_clk);
        chk("rst_busy", o_busy, 0);
        chk("rst_spike", o_spike, 0);
        chk("rst_vld", o_winner_vld, 0);
        chk("rst_drop", o_drop, 0);
        chk("rst_winner", o_winner, 0);
        check_params("rst", m);

        send(pack(0, 0, 0, 0), 5, 5, 1);
        wait_idle();
        for (int k = 0; k < N; k++)
            chk($sformatf("decay1_th[%0d]", k), longint'(o_threshold[k*V +: V]), 255);

        do_reset();
        send(pack(0, 300, 0, 500), 200, 0, 1);
        wait_idle();
        chk("learn_w1_3", longint'(o_weight_1[3*WW +: WW]), 72);
        chk("learn_w2_3", longint'(o_weight_2[3*WW +: WW]), 60);
        chk("learn_th_3", longint'(o_threshold[3*V +: V]), 271);

        send(pack(400, 400, 0, 0), 10, 20, 1);

        send(pack(0, 0, 123, 0), 50, 60, 1);
        @(negedge i_clk);
        i_event_valid = 1'b1;
        i_neuron_out  = pack(999, 0, 0, 0);
        #1 chk("drop_scan", o_drop, 1);
        @(posedge i_clk);
        #1 i_event_valid = 1'b0;
        @(negedge i_clk);
        chk("drop_pulse_end", o_drop, 0);

        send(pack(0, 77, 0, 0), 400, 400, 0);

        for (int i = 0; i < 300; i++)
            send(pack(0, 0, 0, 0), $urandom_range(0, 511), $urandom_range(0, 511), $urandom_range(0, 1));
        wait_idle();
        for (int k = 0; k < N; k++)
            chk($sformatf("floor_th[%0d]", k), longint'(o_threshold[k*V +: V]), 0);

        do_reset();
        send(pack(0, 0, 700, 0), 300, 100, 1);
        repeat (N + 2) @(posedge i_clk);
        #1 chk("w2_phase_w1", longint'(o_weight_1[2*WW +: WW]), 78);
        chk("w2_phase_busy", o_busy, 1);
        #1 i_rst = 1'b1;
        #1;
        chk("arst_spike", o_spike, 0);
        chk("arst_busy", o_busy, 0);
        chk("arst_w1_2", longint'(o_weight_1[2*WW +: WW]), 64);
        chk("arst_w2_2", longint'(o_weight_2[2*WW +: WW]), 64);
        chk("arst_th_2", longint'(o_threshold[2*V +: V]), 256);
        model_init();
        pq.delete();
        chk("arst_spike_q", sq.size(), 0);
        @(negedge i_clk);
        #2 i_rst = 1'b0;

        for (int i = 0; i < 80; i++) begin
            prev = 0;
            for (int k = 0; k < N; k++) begin
                case ($urandom_range(0, 3))
                    0:       v = 0;
                    1:       v = $urandom_range(1, 600);
                    2:       v = $urandom_range(1, TH_MAX);
                    default: v = prev;
                endcase
                outs[k*V +: V] = V'(v);
                prev = v;
            end
            send(outs, $urandom_range(0, 511), $urandom_range(0, 511), $urandom_range(0, 1));
        end

        wait_idle();
        repeat (3) @(negedge i_clk);
        chk("spike_q_empty", sq.size(), 0);
        chk("param_q_empty", pq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
